// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owner and the latched command.
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_PC   = 1'b0,
        OWN_LDST = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wrdata;
        logic [3:0]        byte_en;
        logic              is_wr;
        arb_owner_t        owner;
    } arb_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory command/return signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] pc_addr;
    logic          pc_rd;
    logic [3:0]    pc_byte_en;
    logic          pc_waitrequest;
    logic [DW-1:0] pc_rddata;
    logic          pc_rddatavalid;

    logic [AW-1:0] ldst_addr;
    logic          ldst_rd;
    logic          ldst_wr;
    logic [DW-1:0] ldst_wrdata;
    logic [3:0]    ldst_byte_en;
    logic          ldst_waitrequest;
    logic [DW-1:0] ldst_rddata;
    logic          ldst_rddatavalid;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wrdata;
    logic [3:0]    mem_byte_en;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rddata;

    modport slave (
        input  pc_addr, pc_rd, pc_byte_en,
        input  ldst_addr, ldst_rd, ldst_wr, ldst_wrdata, ldst_byte_en,
        input  mem_rddata,
        output pc_waitrequest, pc_rddata, pc_rddatavalid,
        output ldst_waitrequest, ldst_rddata, ldst_rddatavalid,
        output mem_addr, mem_wrdata, mem_byte_en, mem_rd, mem_wr
    );

    modport master (
        output pc_addr, pc_rd, pc_byte_en,
        output ldst_addr, ldst_rd, ldst_wr, ldst_wrdata, ldst_byte_en,
        output mem_rddata,
        input  pc_waitrequest, pc_rddata, pc_rddatavalid,
        input  ldst_waitrequest, ldst_rddata, ldst_rddatavalid,
        input  mem_addr, mem_wrdata, mem_byte_en, mem_rd, mem_wr
    );

endinterface

// File: rtl/mem_arb_rd_tracker.sv
// Read-latency tracker: counts down RD_LAT after the read strobe, captures memory data into the
// owning port's register and pulses that port's valid one cycle later.
module mem_arb_rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          active,
    input  arb_owner_t    owner,
    input  logic [DW-1:0] mem_rddata,
    output logic          done,
    output logic [DW-1:0] pc_rddata,
    output logic          pc_rddatavalid,
    output logic [DW-1:0] ldst_rddata,
    output logic          ldst_rddatavalid
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [CW-1:0] cnt_q;

    assign done = active && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q            <= '0;
            pc_rddata        <= '0;
            pc_rddatavalid   <= 1'b0;
            ldst_rddata      <= '0;
            ldst_rddatavalid <= 1'b0;
        end else begin
            pc_rddatavalid   <= done && (owner == OWN_PC);
            ldst_rddatavalid <= done && (owner == OWN_LDST);
            if (load) begin
                cnt_q <= CW'(RD_LAT - 1);
            end else if (active && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            // only the owner's data register moves; the other port keeps its last return
            if (done && (owner == OWN_PC)) begin
                pc_rddata <= mem_rddata;
            end
            if (done && (owner == OWN_LDST)) begin
                ldst_rddata <= mem_rddata;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory between fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed ldst-over-pc priority.
//
// state | meaning
// IDLE  | accepting; winner's waitrequest drops combinationally, command latched
// ISSUE | registered mem_rd/mem_wr strobe is on the bus
// WAIT  | read latency running; leaves when the tracker captures the data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = ARB_AW,
    parameter int DW     = ARB_DW,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state_q, state_d;
    arb_cmd_t   cmd_q, cmd_d;
    logic       accept;
    logic       grant_ldst;
    logic       pc_req, ldst_req;
    logic       mem_rd_q, mem_wr_q;
    logic       rd_done;

`ifdef MEM_ARB_RR_EN
    arb_owner_t last_grant_q;
`endif

    assign pc_req   = bus.pc_rd;
    assign ldst_req = bus.ldst_rd | bus.ldst_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        accept                = 1'b0;
        bus.pc_waitrequest    = 1'b1;
        bus.ldst_waitrequest  = 1'b1;
`ifdef MEM_ARB_RR_EN
        grant_ldst = ldst_req && (!pc_req || (last_grant_q == OWN_PC));
`else
        grant_ldst = ldst_req;
`endif
        cmd_d         = '0;
        cmd_d.addr    = ARB_AW'(grant_ldst ? bus.ldst_addr : bus.pc_addr);
        cmd_d.wrdata  = grant_ldst ? ARB_DW'(bus.ldst_wrdata) : '0;
        cmd_d.byte_en = grant_ldst ? bus.ldst_byte_en : bus.pc_byte_en;
        // a simultaneous ldst read+write is treated as a store
        cmd_d.is_wr   = grant_ldst && bus.ldst_wr;
        cmd_d.owner   = grant_ldst ? OWN_LDST : OWN_PC;

        case (state_q)
            IDLE: begin
                if ((pc_req || ldst_req) && !reset) begin
                    accept               = 1'b1;
                    bus.ldst_waitrequest = !grant_ldst;
                    bus.pc_waitrequest   = grant_ldst;
                    state_d              = ISSUE;
                end
            end
            ISSUE:   state_d = cmd_q.is_wr ? IDLE : WAIT;
            WAIT:    if (rd_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= OWN_LDST;
`endif
        end else begin
            mem_rd_q <= accept && !cmd_d.is_wr;
            mem_wr_q <= accept && cmd_d.is_wr;
            if (accept) begin
                cmd_q <= cmd_d;
`ifdef MEM_ARB_RR_EN
                last_grant_q <= cmd_d.owner;
`endif
            end
        end
    end

    assign bus.mem_addr    = AW'(cmd_q.addr);
    assign bus.mem_wrdata  = DW'(cmd_q.wrdata);
    assign bus.mem_byte_en = cmd_q.byte_en;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;

    mem_arb_rd_tracker #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk              (clk),
        .reset            (reset),
        .load             ((state_q == ISSUE) && !cmd_q.is_wr),
        .active           (state_q == WAIT),
        .owner            (cmd_q.owner),
        .mem_rddata       (bus.mem_rddata),
        .done             (rd_done),
        .pc_rddata        (bus.pc_rddata),
        .pc_rddatavalid   (bus.pc_rddatavalid),
        .ldst_rddata      (bus.ldst_rddata),
        .ldst_rddatavalid (bus.ldst_rddatavalid)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing model checked every cycle on an RD_LAT=1 instance,
// directed literal checks, plus a directed RD_LAT=3 instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus  ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    // memory models: data appears exactly LAT cycles after the read strobe, garbage otherwise
    logic [31:0] p1_d;
    logic        p1_v = 1'b0;
    always @(posedge clk) begin
        p1_v <= bus.mem_rd;
        p1_d <= memfn(bus.mem_addr);
    end
    assign bus.mem_rddata = p1_v ? p1_d : 32'hBAD0_BAD0;

    logic [31:0] p3_d [3];
    logic [2:0]  p3_v = 3'b000;
    always @(posedge clk) begin
        p3_v    <= {p3_v[1:0], bus3.mem_rd};
        p3_d[2] <= p3_d[1];
        p3_d[1] <= p3_d[0];
        p3_d[0] <= memfn(bus3.mem_addr);
    end
    assign bus3.mem_rddata = p3_v[2] ? p3_d[2] : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // transaction-level model: acceptance only when free, strobe at t+1, valid at t+2+LAT
    int          free_at = 0, strobe_at = -1, valid_at = -1;
    logic        m_wr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    arb_owner_t  m_owner = OWN_PC, last_g = OWN_LDST;
    logic [31:0] exp_pc_data = '0, exp_ldst_data = '0;
    logic        rst_prev = 1'b0;
    logic        pc_r, ld_r, take_ldst, acc;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_pc_wait", bus.pc_waitrequest, 1'b1);
            chk("rst_ldst_wait", bus.ldst_waitrequest, 1'b1);
            if (rst_prev) begin
                chk("rst_mem_rd", bus.mem_rd, 1'b0);
                chk("rst_mem_wr", bus.mem_wr, 1'b0);
                chk("rst_pc_valid", bus.pc_rddatavalid, 1'b0);
                chk("rst_ldst_valid", bus.ldst_rddatavalid, 1'b0);
                chk("rst_pc_data", bus.pc_rddata, 32'h0);
                chk("rst_ldst_data", bus.ldst_rddata, 32'h0);
            end
            free_at = 0; strobe_at = -1; valid_at = -1;
            exp_pc_data = '0; exp_ldst_data = '0; last_g = OWN_LDST;
        end else begin
            pc_r = bus.pc_rd;
            ld_r = bus.ldst_rd | bus.ldst_wr;
            acc  = (cyc >= free_at) && (pc_r || ld_r);
`ifdef MEM_ARB_RR_EN
            take_ldst = ld_r && !(pc_r && last_g == OWN_LDST);
`else
            take_ldst = ld_r;
`endif
            chk("pc_wait", bus.pc_waitrequest, !(acc && !take_ldst));
            chk("ldst_wait", bus.ldst_waitrequest, !(acc && take_ldst));
            chk("mem_rd", bus.mem_rd, (cyc == strobe_at) && !m_wr);
            chk("mem_wr", bus.mem_wr, (cyc == strobe_at) && m_wr);
            if (cyc == strobe_at) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_be", bus.mem_byte_en, m_be);
                if (m_wr) chk("mem_wrdata", bus.mem_wrdata, m_wdata);
            end
            if (cyc == valid_at) begin
                if (m_owner == OWN_PC) exp_pc_data = m_rdata;
                else                   exp_ldst_data = m_rdata;
            end
            chk("pc_valid", bus.pc_rddatavalid, (cyc == valid_at) && (m_owner == OWN_PC));
            chk("ldst_valid", bus.ldst_rddatavalid, (cyc == valid_at) && (m_owner == OWN_LDST));
            chk("pc_rddata", bus.pc_rddata, exp_pc_data);
            chk("ldst_rddata", bus.ldst_rddata, exp_ldst_data);
            if (acc) begin
                m_owner   = take_ldst ? OWN_LDST : OWN_PC;
                m_addr    = take_ldst ? bus.ldst_addr : bus.pc_addr;
                m_be      = take_ldst ? bus.ldst_byte_en : bus.pc_byte_en;
                m_wr      = take_ldst && bus.ldst_wr;
                m_wdata   = bus.ldst_wrdata;
                strobe_at = cyc + 1;
                if (m_wr) begin
                    free_at = cyc + 2;
                end else begin
                    valid_at = cyc + 2 + LAT;
                    free_at  = valid_at;
                    m_rdata  = memfn(m_addr);
                end
                last_g = m_owner;
            end
        end
        rst_prev = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
        @(negedge clk);
    endtask

    task automatic pc_req(input logic [31:0] a, input logic [3:0] be);
        bus.pc_addr = a; bus.pc_byte_en = be; bus.pc_rd = 1'b1;
    endtask

    task automatic ld_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic rd, input logic wr);
        bus.ldst_addr = a; bus.ldst_wrdata = d; bus.ldst_byte_en = be;
        bus.ldst_rd = rd; bus.ldst_wr = wr;
    endtask

    task automatic wait_acc(output arb_owner_t who, output int t);
        who = OWN_PC;
        t   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.ldst_waitrequest) begin who = OWN_LDST; t = cyc; return; end
            if (!bus.pc_waitrequest)   begin who = OWN_PC;   t = cyc; return; end
            tick();
        end
        checks++;
        failures++;
        $display("FAIL acc_timeout: no acceptance within 40 cycles (cycle %0d)", cyc);
        bus.pc_rd = 1'b0; bus.ldst_rd = 1'b0; bus.ldst_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_owner_t who;
        int t, t2;

        bus.pc_addr = '0; bus.pc_rd = 1'b0; bus.pc_byte_en = '0;
        bus.ldst_addr = '0; bus.ldst_rd = 1'b0; bus.ldst_wr = 1'b0;
        bus.ldst_wrdata = '0; bus.ldst_byte_en = '0;
        bus3.pc_addr = '0; bus3.pc_rd = 1'b0; bus3.pc_byte_en = '0;
        bus3.ldst_addr = '0; bus3.ldst_rd = 1'b0; bus3.ldst_wr = 1'b0;
        bus3.ldst_wrdata = '0; bus3.ldst_byte_en = '0;

        reset = 1'b1;
        idle(3);
        reset = 1'b0;

        // back-to-back ties: the granted port re-requests immediately
        pc_req(32'h200, 4'hF);
        ld_req(32'h300, 32'h0, 4'hF, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_acc(who, t);
`ifdef MEM_ARB_RR_EN
            chk("tie_seq", who, (k % 2 == 0) ? OWN_PC : OWN_LDST);
`else
            chk("tie_seq", who, OWN_LDST);
`endif
            tick();
            if (who == OWN_LDST) bus.ldst_addr = bus.ldst_addr + 32'd4;
            else                 bus.pc_addr   = bus.pc_addr + 32'd4;
        end
        bus.ldst_rd = 1'b0;
        wait_acc(who, t);
        chk("tie_tail_owner", who, OWN_PC);
        tick();
        bus.pc_rd = 1'b0;
        idle(4);

        // fetch alone
        pc_req(32'h10, 4'hF);
        wait_acc(who, t);
        tick();
        bus.pc_rd = 1'b0;
        @(negedge clk);
        chk("A_mem_rd", bus.mem_rd, 1'b1);
        chk("A_mem_addr", bus.mem_addr, 32'h10);
        goto_cycle(t + 3);
        chk("A_pc_valid", bus.pc_rddatavalid, 1'b1);
        chk("A_pc_data", bus.pc_rddata, 32'hDEAD_BEEF);
        chk("A_ldst_valid", bus.ldst_rddatavalid, 1'b0);
        idle(3);

        // store, then a fetch presented the next cycle
        ld_req(32'h40, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
        wait_acc(who, t);
        chk("B_owner", who, OWN_LDST);
        tick();
        bus.ldst_wr = 1'b0;
        pc_req(32'h44, 4'h3);
        @(negedge clk);
        chk("B_mem_wr", bus.mem_wr, 1'b1);
        chk("B_mem_rd", bus.mem_rd, 1'b0);
        chk("B_mem_addr", bus.mem_addr, 32'h40);
        chk("B_mem_wrdata", bus.mem_wrdata, 32'h1234_5678);
        chk("B_mem_be", bus.mem_byte_en, 4'hF);
        tick();
        wait_acc(who, t2);
        chk("B_next_acc", t2, t + 2);
        tick();
        bus.pc_rd = 1'b0;
        idle(4);

        // simultaneous reads
        pc_req(32'h0, 4'hF);
        ld_req(32'h80, 32'h0, 4'hF, 1'b1, 1'b0);
        wait_acc(who, t);
        chk("C_first_owner", who, OWN_LDST);
        tick();
        bus.ldst_rd = 1'b0;
        wait_acc(who, t2);
        chk("C_second_owner", who, OWN_PC);
        chk("C_second_acc", t2, t + 3);
        tick();
        bus.pc_rd = 1'b0;
        goto_cycle(t2 + 3);
        chk("C_pc_valid", bus.pc_rddatavalid, 1'b1);
        chk("C_pc_data", bus.pc_rddata, 32'hA5A5_FFFF);
        idle(3);

        // read and write together act as a store
        ld_req(32'h84, 32'hCAFE_F00D, 4'h5, 1'b1, 1'b1);
        wait_acc(who, t);
        tick();
        bus.ldst_rd = 1'b0;
        bus.ldst_wr = 1'b0;
        @(negedge clk);
        chk("E_mem_wr", bus.mem_wr, 1'b1);
        chk("E_mem_rd", bus.mem_rd, 1'b0);
        idle(4);

        // mixed traffic
        for (int k = 0; k < 6; k++) begin
            if (k % 3 != 1) pc_req(32'h1000 + 32'(k * 8), 4'hF);
            if (k % 3 != 0) ld_req(32'h2000 + 32'(k * 12), 32'h0, 4'(k), 1'b1, 1'b0);
            while (bus.pc_rd || bus.ldst_rd) begin
                wait_acc(who, t);
                tick();
                if (who == OWN_LDST) bus.ldst_rd = 1'b0;
                else                 bus.pc_rd   = 1'b0;
            end
        end
        idle(5);

        // reset while a read is waiting for data
        ld_req(32'h300, 32'h0, 4'hF, 1'b1, 1'b0);
        wait_acc(who, t);
        tick();
        bus.ldst_rd = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("F_pc_wait", bus.pc_waitrequest, 1'b1);
        chk("F_ldst_wait", bus.ldst_waitrequest, 1'b1);
        tick();
        pc_req(32'h10, 4'hF);
        @(negedge clk);
        chk("F_ldst_valid", bus.ldst_rddatavalid, 1'b0);
        chk("F_mem_rd", bus.mem_rd, 1'b0);
        chk("F_pc_wait_req", bus.pc_waitrequest, 1'b1);
        tick();
        reset = 1'b0;
        wait_acc(who, t2);
        chk("F_acc_after_reset", t2, t + 4);
        chk("F_owner", who, OWN_PC);
        tick();
        bus.pc_rd = 1'b0;
        goto_cycle(t2 + 3);
        chk("F_pc_valid", bus.pc_rddatavalid, 1'b1);
        chk("F_pc_data", bus.pc_rddata, 32'hDEAD_BEEF);
        idle(3);

        // RD_LAT=3 instance: load with a fetch queued behind it
        bus3.ldst_addr = 32'h100; bus3.ldst_byte_en = 4'hF; bus3.ldst_rd = 1'b1;
        @(negedge clk);
        chk("H_ldst_acc", bus3.ldst_waitrequest, 1'b0);
        tick();
        bus3.ldst_rd = 1'b0;
        bus3.pc_addr = 32'h10; bus3.pc_byte_en = 4'hF; bus3.pc_rd = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("H_pc_wait", bus3.pc_waitrequest, 1'b1);
            chk("H_ldst_wait", bus3.ldst_waitrequest, 1'b1);
            chk("H_ldst_valid_early", bus3.ldst_rddatavalid, 1'b0);
            tick();
        end
        @(negedge clk);
        chk("H_ldst_valid", bus3.ldst_rddatavalid, 1'b1);
        chk("H_ldst_data", bus3.ldst_rddata, 32'hA4A5_FEFF);
        chk("H_pc_acc", bus3.pc_waitrequest, 1'b0);
        tick();
        bus3.pc_rd = 1'b0;
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
